// File: rtl/iterative_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the operands one CHUNK at a time,
// MSB chunk first, and stops at the first differing chunk.
module iterative_magnitude_comparator #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned CHUNK   = 4,
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               a_eq_b,
    output logic               a_gt_b,
    output logic               a_lt_b,
    input  logic               clr_counts,
    output logic [COUNT_W-1:0] eq_count,
    output logic [COUNT_W-1:0] gt_count,
    output logic [COUNT_W-1:0] lt_count
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPARE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NCHUNK - 1);
    localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sgn_q, sgn_d;
    logic               eq_q, eq_d;
    logic               gt_q, gt_d;
    logic               lt_q, lt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [COUNT_W-1:0] eq_cnt_q, eq_cnt_d;
    logic [COUNT_W-1:0] gt_cnt_q, gt_cnt_d;
    logic [COUNT_W-1:0] lt_cnt_q, lt_cnt_d;
    logic [CHUNK-1:0]   ca, cb;
    logic               enter_done;

    // Operands are shifted left each step, so the chunk under test is always the top one.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        sgn_d       = sgn_q;
        eq_d        = eq_q;
        gt_d        = gt_q;
        lt_d        = lt_q;
        eq_cnt_d    = eq_cnt_q;
        gt_cnt_d    = gt_cnt_q;
        lt_cnt_d    = lt_cnt_q;
        enter_done  = 1'b0;
        ca          = a_q[WIDTH-1 -: CHUNK];
        cb          = b_q[WIDTH-1 -: CHUNK];

        // Flipping the sign bit maps two's-complement order onto unsigned order.
        if (sgn_q && (idx_q == IDX_TOP)) begin
            ca = ca ^ MSB_MASK;
            cb = cb ^ MSB_MASK;
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = signed_mode;
                    idx_d   = IDX_TOP;
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (ca > cb) begin
                    {eq_d, gt_d, lt_d} = 3'b010;
                    enter_done         = 1'b1;
                end else if (ca < cb) begin
                    {eq_d, gt_d, lt_d} = 3'b001;
                    enter_done         = 1'b1;
                end else if (idx_q != '0) begin
                    idx_d = idx_q - IDX_W'(1);
                    a_d   = a_q << CHUNK;
                    b_d   = b_q << CHUNK;
                end else begin
                    {eq_d, gt_d, lt_d} = 3'b100;
                    enter_done         = 1'b1;
                end
                if (enter_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);

        // Saturating outcome counters; a clear on the same edge takes priority.
        if (enter_done) begin
            if (eq_d && (eq_cnt_q != '1)) eq_cnt_d = eq_cnt_q + COUNT_W'(1);
            if (gt_d && (gt_cnt_q != '1)) gt_cnt_d = gt_cnt_q + COUNT_W'(1);
            if (lt_d && (lt_cnt_q != '1)) lt_cnt_d = lt_cnt_q + COUNT_W'(1);
        end
        if (clr_counts) begin
            eq_cnt_d = '0;
            gt_cnt_d = '0;
            lt_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sgn_q       <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            eq_cnt_q    <= '0;
            gt_cnt_q    <= '0;
            lt_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sgn_q       <= sgn_d;
            eq_q        <= eq_d;
            gt_q        <= gt_d;
            lt_q        <= lt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            eq_cnt_q    <= eq_cnt_d;
            gt_cnt_q    <= gt_cnt_d;
            lt_cnt_q    <= lt_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign a_eq_b    = eq_q;
    assign a_gt_b    = gt_q;
    assign a_lt_b    = lt_q;
    assign eq_count  = eq_cnt_q;
    assign gt_count  = gt_cnt_q;
    assign lt_count  = lt_cnt_q;

endmodule

// File: tb/tb_iterative_magnitude_comparator.sv
// Bench for iterative_magnitude_comparator (16-bit, 4-bit chunks, 2-bit counters).
module tb_iterative_magnitude_comparator;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned CHUNK   = 4;
    localparam int unsigned NCHUNK  = WIDTH / CHUNK;
    localparam int unsigned COUNT_W = 2;
    localparam int          TIMEOUT = 40;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a, b;
    logic               signed_mode;
    logic               out_valid;
    logic               out_ready;
    logic               a_eq_b, a_gt_b, a_lt_b;
    logic               clr_counts;
    logic [COUNT_W-1:0] eq_count, gt_count, lt_count;

    int checks = 0;
    int errors = 0;
    int m_eq = 0, m_gt = 0, m_lt = 0;

    typedef struct {
        logic [2:0] flags;   // {eq, gt, lt}
        int         k;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [2:0]  flags;
        int          k;
        int          hold;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];

    iterative_magnitude_comparator #(
        .WIDTH(WIDTH), .CHUNK(CHUNK), .COUNT_W(COUNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_eq_b(a_eq_b), .a_gt_b(a_gt_b), .a_lt_b(a_lt_b),
        .clr_counts(clr_counts),
        .eq_count(eq_count), .gt_count(gt_count), .lt_count(lt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v < 3) ? v + 1 : 3;
    endfunction

    // Independent reference: full-width compare plus first-differing-chunk position.
    function automatic exp_t ref_cmp(input logic [15:0] ra, input logic [15:0] rb, input logic rs);
        exp_t e;
        logic gt, lt;
        gt = rs ? ($signed(ra) > $signed(rb)) : (ra > rb);
        lt = rs ? ($signed(ra) < $signed(rb)) : (ra < rb);
        e.flags = {(ra == rb), gt, lt};
        e.k = NCHUNK;
        for (int i = NCHUNK - 1; i >= 0; i--) begin
            if (ra[i*CHUNK +: CHUNK] != rb[i*CHUNK +: CHUNK]) begin
                e.k = NCHUNK - i;
                break;
            end
        end
        return e;
    endfunction

    function automatic logic [5:0] model_counts();
        return {COUNT_W'(m_eq), COUNT_W'(m_gt), COUNT_W'(m_lt)};
    endfunction

    // One full transaction: accept, measure latency, check result, optional hold, retire.
    task automatic do_compare(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                              input exp_t e, input int hold);
        exp_t got;
        int cyc;
        logic [2:0] flags0;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        a = va; b = vb; signed_mode = vs; in_valid = 1'b1;
        tick();
        sb.push_back(e);
        in_valid = 1'b0;
        a = ~va; b = ~vb; signed_mode = ~vs;
        cyc = 0;
        while (!out_valid && cyc < TIMEOUT) begin
            tick();
            cyc++;
        end
        got = sb.pop_front();
        if (!out_valid) begin
            chk("out_valid_timeout", 32'(out_valid), 32'd1);
            return;
        end
        chk("latency", 32'(cyc), 32'(got.k));
        chk("flags", 32'({a_eq_b, a_gt_b, a_lt_b}), 32'(got.flags));
        if (got.flags[2]) m_eq = sat(m_eq);
        if (got.flags[1]) m_gt = sat(m_gt);
        if (got.flags[0]) m_lt = sat(m_lt);
        chk("counts", 32'({eq_count, gt_count, lt_count}), 32'(model_counts()));
        flags0 = {a_eq_b, a_gt_b, a_lt_b};
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; a = 16'h0F0F; b = 16'hF0F0;
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_flags", 32'({a_eq_b, a_gt_b, a_lt_b}), 32'(flags0));
            chk("hold_counts", 32'({eq_count, gt_count, lt_count}), 32'(model_counts()));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("retire_valid", 32'(out_valid), 32'd0);
        chk("retire_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h1234, 1'b0, 3'b100, 4, 5};
        vecs[1] = '{16'h8000, 16'h7FFF, 1'b0, 3'b010, 1, 0};
        vecs[2] = '{16'h8000, 16'h7FFF, 1'b1, 3'b001, 1, 0};
        vecs[3] = '{16'h1235, 16'h1234, 1'b0, 3'b010, 4, 0};
        vecs[4] = '{16'hFFFE, 16'hFFFF, 1'b1, 3'b001, 4, 2};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 3'b100, 4, 0};
        vecs[6] = '{16'h7FFF, 16'h8000, 1'b1, 3'b010, 1, 0};
        vecs[7] = '{16'h0010, 16'h0001, 1'b0, 3'b010, 3, 0};
        vecs[8] = '{16'h0100, 16'h0F00, 1'b0, 3'b001, 2, 0};
        vecs[9] = '{16'hFFFF, 16'h0001, 1'b1, 3'b001, 1, 1};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
        out_ready = 1'b0; clr_counts = 1'b0;
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_flags", 32'({a_eq_b, a_gt_b, a_lt_b}), 32'd0);
        chk("rst_counts", 32'({eq_count, gt_count, lt_count}), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            exp_t e;
            e.flags = vecs[i].flags;
            e.k = vecs[i].k;
            do_compare(vecs[i].a, vecs[i].b, vecs[i].s, e, vecs[i].hold);
        end

        for (int i = 0; i < 24; i++) begin
            logic [15:0] ra, rb;
            logic rs;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 1) == 1) ? (ra ^ (16'h1 << $urandom_range(0, 15))) : 16'($urandom);
            if (i % 5 == 0) rb = ra;
            rs = 1'($urandom_range(0, 1));
            do_compare(ra, rb, rs, ref_cmp(ra, rb, rs), 0);
        end

        // Counter saturation and clear-wins-over-increment.
        clr_counts = 1'b1;
        tick();
        clr_counts = 1'b0;
        m_eq = 0; m_gt = 0; m_lt = 0;
        chk("clr_counts", 32'({eq_count, gt_count, lt_count}), 32'd0);
        for (int i = 0; i < 5; i++) begin
            do_compare(16'h8000, 16'h7FFF, 1'b0, ref_cmp(16'h8000, 16'h7FFF, 1'b0), 0);
        end
        chk("gt_saturated", 32'(gt_count), 32'd3);
        a = 16'h8000; b = 16'h7FFF; signed_mode = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        clr_counts = 1'b1;
        tick();
        clr_counts = 1'b0;
        m_gt = 0;
        chk("clr_on_done_valid", 32'(out_valid), 32'd1);
        chk("clr_on_done_flags", 32'({a_eq_b, a_gt_b, a_lt_b}), 32'b010);
        chk("clr_on_done_counts", 32'({eq_count, gt_count, lt_count}), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset during the second compare cycle of an equal (4-cycle) compare.
        do_compare(16'h0001, 16'h0002, 1'b0, ref_cmp(16'h0001, 16'h0002, 1'b0), 0);
        a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_eq = 0; m_gt = 0; m_lt = 0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_flags", 32'({a_eq_b, a_gt_b, a_lt_b}), 32'd0);
        chk("midrst_counts", 32'({eq_count, gt_count, lt_count}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_no_result", 32'(out_valid), 32'd0);
        end
        do_compare(16'hFFFE, 16'hFFFF, 1'b1, ref_cmp(16'hFFFE, 16'hFFFF, 1'b1), 0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iterative_magnitude_comparator.md
Name: iterative_magnitude_comparator

Overview:
Parametrised, multi-cycle successor to the team's 16-bit combinational equal/greater/less comparator. Compares two WIDTH-bit operands chunk by chunk, MSB chunk first, with early exit on the first differing chunk. Supports signed and unsigned modes, valid/ready handshakes on both sides, and saturating per-outcome event counters. Sits in the datapath wherever wide compares must not occupy a single-cycle critical path.

Parameters:
WIDTH, 16, operand width in bits; must be an integer multiple of CHUNK.
CHUNK, 4, bits examined per compare cycle; NCHUNK = WIDTH/CHUNK.
COUNT_W, 8, width of each saturating event counter.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operand pair offered.
in_ready  out  1  block can accept an operand pair.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
signed_mode  in  1  1 = two's-complement compare; 0 = unsigned; sampled with operands.
out_valid  out  1  result available.
out_ready  in  1  consumer accepts the result.
a_eq_b  out  1  A == B.
a_gt_b  out  1  A > B.
a_lt_b  out  1  A < B.
clr_counts  in  1  synchronous clear of all three counters.
eq_count  out  COUNT_W  number of completed eq results (saturating).
gt_count  out  COUNT_W  number of completed gt results (saturating).
lt_count  out  COUNT_W  number of completed lt results (saturating).

Behaviour:
- Reset (rst=1 at an edge): state IDLE; in_ready=1 in IDLE; out_valid=0; a_eq_b=a_gt_b=a_lt_b=0; all counters 0. Reset overrides any in-flight compare; the partial result is discarded and not counted.
- FSM states: IDLE, COMPARE, DONE.
- IDLE: in_ready=1. If in_valid, latch a, b, signed_mode; chunk index idx=NCHUNK-1; go to COMPARE. Otherwise stay.
- COMPARE: in_ready=0. Each cycle, compare chunk idx of the latched A and B as unsigned CHUNK-bit values.
  - Signed mode: on the top chunk (idx=NCHUNK-1) only, invert the MSB of both chunk values before comparing. Lower chunks are always compared unsigned.
  - Chunks differ: set the gt or lt flag, clear the other two flags, go to DONE.
  - Chunks equal and idx>0: idx decrements; stay in COMPARE.
  - Chunks equal and idx=0: set a_eq_b=1, clear the other two flags, go to DONE.
- Latency: the handshake is accepted at edge T. If k chunks are examined (1 ≤ k ≤ NCHUNK), out_valid is 1 after edge T+k.
- DONE: out_valid=1; result flags held stable and exactly one-hot. When out_ready=1, go to IDLE at that edge. in_ready stays 0 in DONE (no overlap of accept and retire). After leaving DONE, the flags keep their last values but are valid only while out_valid=1.
- Counters: the counter matching the result increments by 1 on the edge that enters DONE, and saturates at 2^COUNT_W-1. If clr_counts=1 on the same edge, clr_counts wins and all counters become 0. clr_counts is ignored only while rst=1.
- Operand inputs are don't-care outside the IDLE accept cycle. Changing a, b or signed_mode mid-compare has no effect.
- NCHUNK=1 is legal: every compare takes 1 cycle.

Test Plan:
- WIDTH=16, CHUNK=4, unsigned; A=0x1234, B=0x1234 -> out_valid 4 cycles after accept; eq=1; eq_count=1.
- A=0x8000, B=0x7FFF, signed_mode=0 -> gt=1 after 1 cycle. Same operands with signed_mode=1 -> lt=1 after 1 cycle.
- A=0x1235, B=0x1234 -> gt=1 after 4 cycles. A=0xFFFE, B=0xFFFF, signed_mode=1 -> lt=1 after 4 cycles.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and flags stable, in_ready=0, counter increments once. Assert in_valid with new operands during this time -> not accepted.
- COUNT_W=2; issue 5 gt compares -> gt_count saturates at 3. Assert clr_counts on the edge a 6th result enters DONE -> all counters 0.
- Assert rst during the 2nd COMPARE cycle -> next cycle IDLE, in_ready=1, out_valid=0, flags 0, counters 0. A new compare then completes correctly.
